// File: rtl/mips_pkg.sv
// Shared constants and enums for the multicycle MIPS datapath: opcodes,
// funct codes, ALU operations and control FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ADDR,
        MEM_RD,
        MEM_WR,
        WB_R,
        WB_MEM,
        WB_I,
        BRANCH,
        JUMP
    } state_t;

    function automatic logic funct_valid(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic alu_op_t funct_to_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU: wrapping add/sub, bitwise and/or, signed slt.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
            default: y = a + b;
        endcase
    end

    assign zero = ~|y;

endmodule

// File: rtl/mips_machine.sv
// Multicycle MIPS-32 datapath with Moore control FSM, register file and
// internal data memory; instructions are supplied externally on ins_in.
module mips_machine
    import mips_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins_in,
    output logic [31:0] PCOut,
    output logic [31:0] PCIn,
    output logic [31:0] Ai,
    output logic [31:0] Bi,
    output logic [31:0] rd2,
    output logic [31:0] datamem_out,
    output logic [31:0] mux2_outt,
    output logic [4:0]  mux5_out
);

    localparam int AW = $clog2(DMEM_WORDS);

    state_t      state, state_nx;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext, jump_target;
    logic [31:0] rd1_val, rd2_val;

    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_t     alu_op;
    logic        alu_zero;

    logic [31:0] pc_mux, wb_data;
    logic [4:0]  wb_reg;
    logic        pc_write, reg_write;
    logic [AW-1:0] mem_idx;
    logic        unused_bits;

    assign opcode      = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign funct       = ir[5:0];
    assign imm_ext     = {{16{ir[15]}}, ir[15:0]};
    assign jump_target = {pc[31:28], ir[25:0], 2'b00};
    assign mem_idx     = alu_out[AW+1:2];
    assign unused_bits = ^{ir[10:6], alu_out[31:AW+2], alu_out[1:0]};

    assign rd1_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rd2_val = (rt == 5'd0) ? 32'd0 : regs[rt];

    mips_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // One shared ALU: PC+4 in FETCH, branch target in DECODE, operands later.
    always_comb begin
        alu_a  = a;
        alu_b  = b;
        alu_op = ALU_ADD;
        case (state)
            FETCH: begin
                alu_a = pc;
                alu_b = 32'd4;
            end
            DECODE: begin
                alu_a = pc;
                alu_b = {imm_ext[29:0], 2'b00};
            end
            EXEC_R: alu_op = funct_to_op(funct);
            EXEC_I, ADDR: alu_b = imm_ext;
            BRANCH: alu_op = ALU_SUB;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH: state_nx = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE: state_nx = funct_valid(funct) ? EXEC_R : FETCH;
                    OP_ADDI:  state_nx = EXEC_I;
                    OP_LW,
                    OP_SW:    state_nx = ADDR;
                    OP_BEQ:   state_nx = BRANCH;
                    OP_J:     state_nx = JUMP;
                    default:  state_nx = FETCH;
                endcase
            end
            EXEC_R:  state_nx = WB_R;
            EXEC_I:  state_nx = WB_I;
            ADDR:    state_nx = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  state_nx = WB_MEM;
            default: state_nx = FETCH;
        endcase
    end

    always_comb begin
        case (state)
            JUMP:    pc_mux = jump_target;
            BRANCH:  pc_mux = alu_out;
            default: pc_mux = alu_y;
        endcase
    end

    assign pc_write  = (state == FETCH) || (state == JUMP) ||
                       ((state == BRANCH) && alu_zero);
    assign reg_write = (state == WB_R) || (state == WB_I) || (state == WB_MEM);
    assign wb_data   = (opcode == OP_LW) ? mdr : alu_out;
    assign wb_reg    = (opcode == OP_RTYPE) ? rd : rt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else begin
            state <= state_nx;
            if (pc_write) pc <= pc_mux;
            case (state)
                FETCH: ir <= ins_in;
                DECODE: begin
                    a       <= rd1_val;
                    b       <= rd2_val;
                    alu_out <= alu_y;
                end
                EXEC_R, EXEC_I, ADDR: alu_out <= alu_y;
                MEM_RD: mdr <= dmem[mem_idx];
                MEM_WR: dmem[mem_idx] <= b;
                default: ;
            endcase
            if (reg_write && (wb_reg != 5'd0)) regs[wb_reg] <= wb_data;
        end
    end

    assign PCOut       = pc;
    // The next-PC mux reads the PC+4 adder even in reset; hold it at 0 there.
    assign PCIn        = rst ? pc_mux : 32'd0;
    assign Ai          = a;
    assign Bi          = b;
    assign rd2         = rd2_val;
    assign datamem_out = mdr;
    assign mux2_outt   = wb_data;
    assign mux5_out    = wb_reg;

endmodule

// File: tb/tb_mips_machine.sv
// Directed program run through the multicycle MIPS machine, checking
// datapath outputs at hand-computed points in each instruction.
module tb_mips_machine;

    logic        clk;
    logic        rst;
    logic [31:0] ins_in;
    logic [31:0] PCOut, PCIn, Ai, Bi, rd2, datamem_out, mux2_outt;
    logic [4:0]  mux5_out;

    int total = 0;
    int bad   = 0;

    mips_machine #(.DMEM_WORDS(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .ins_in      (ins_in),
        .PCOut       (PCOut),
        .PCIn        (PCIn),
        .Ai          (Ai),
        .Bi          (Bi),
        .rd2         (rd2),
        .datamem_out (datamem_out),
        .mux2_outt   (mux2_outt),
        .mux5_out    (mux5_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b0;
        ins_in = 32'h0;
        tick(2);
        chk("rst_pcout", PCOut, 32'h0);
        chk("rst_pcin", PCIn, 32'h0);
        chk("rst_ai", Ai, 32'h0);
        chk("rst_bi", Bi, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_mdr", datamem_out, 32'h0);
        chk("rst_wbdata", mux2_outt, 32'h0);
        chk("rst_wbreg", {27'b0, mux5_out}, 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_pcout", PCOut, 32'h0);

        // addi $1,$0,5 @0
        ins_in = 32'h20010005;
        tick(1);
        chk("fetch_pc4", PCOut, 32'h4);
        tick(2);
        chk("addi_wbreg", {27'b0, mux5_out}, 32'd1);
        chk("addi_wbdata", mux2_outt, 32'd5);
        tick(1);
        chk("addi_pc", PCOut, 32'h4);

        // addi $2,$0,7 @4
        ins_in = 32'h20020007;
        tick(4);
        chk("addi2_pc", PCOut, 32'h8);

        // add $3,$1,$2 @8
        ins_in = 32'h00221820;
        tick(3);
        chk("add_ai", Ai, 32'd5);
        chk("add_bi", Bi, 32'd7);
        chk("add_rd2", rd2, 32'd7);
        chk("add_wbreg", {27'b0, mux5_out}, 32'd3);
        chk("add_wbdata", mux2_outt, 32'd12);
        tick(1);
        chk("add_pc", PCOut, 32'hC);

        // sw $1,0($0) @C
        ins_in = 32'hAC010000;
        tick(4);
        chk("sw_pc", PCOut, 32'h10);

        // beq $0,$0,+2 @10 -> 1C
        ins_in = 32'h10000002;
        tick(2);
        chk("beq_pcin", PCIn, 32'h1C);
        tick(1);
        chk("beq_pc", PCOut, 32'h1C);

        // lw $4,0($0) @1C
        ins_in = 32'h8C040000;
        tick(4);
        chk("lw_mdr", datamem_out, 32'd5);
        chk("lw_wbdata", mux2_outt, 32'd5);
        chk("lw_wbreg", {27'b0, mux5_out}, 32'd4);
        tick(1);
        chk("lw_pc", PCOut, 32'h20);

        // j 0x10 @20 -> 40
        ins_in = 32'h08000010;
        tick(1);
        chk("j_fetch_pc", PCOut, 32'h24);
        tick(1);
        chk("j_pcin", PCIn, 32'h40);
        tick(1);
        chk("j_pc", PCOut, 32'h40);

        // add $5,$4,$1 @40: $4 came from memory
        ins_in = 32'h00812820;
        tick(3);
        chk("add5_ai", Ai, 32'd5);
        chk("add5_wbdata", mux2_outt, 32'd10);
        tick(1);

        // sub $7,$0,$1 -> -5 wraps
        ins_in = 32'h00013822;
        tick(3);
        chk("sub_wbdata", mux2_outt, 32'hFFFFFFFB);
        tick(1);

        // slt $8,$7,$1: -5 < 5 signed
        ins_in = 32'h00E1402A;
        tick(3);
        chk("slt_wbdata", mux2_outt, 32'd1);
        chk("slt_wbreg", {27'b0, mux5_out}, 32'd8);
        tick(1);
        chk("slt_pc", PCOut, 32'h4C);

        // beq $1,$2,+4 not taken @4C
        ins_in = 32'h10220004;
        tick(3);
        chk("beqnt_pc", PCOut, 32'h50);

        // unknown opcode @50: two cycles
        ins_in = 32'hFC000000;
        tick(2);
        chk("nop_pc", PCOut, 32'h54);

        // addi $0,$0,9 @54 must not write $0
        ins_in = 32'h20000009;
        tick(1);
        chk("nop_len_pc", PCOut, 32'h58);
        tick(2);
        chk("addi0_wbdata", mux2_outt, 32'd9);
        tick(1);

        // add $6,$0,$0 @58
        ins_in = 32'h00003020;
        tick(3);
        chk("r0_ai", Ai, 32'd0);
        chk("r0_wbdata", mux2_outt, 32'd0);
        tick(1);
        chk("r0_pc", PCOut, 32'h5C);

        // addi $9,$0,1 aborted by reset in WB_I
        ins_in = 32'h20090001;
        tick(3);
        chk("mid_wbdata", mux2_outt, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_pc", PCOut, 32'h0);
        chk("mid_rst_wbdata", mux2_outt, 32'h0);
        tick(2);
        rst = 1'b1;
        ins_in = 32'h01205020; // add $10,$9,$0
        tick(2);
        chk("mid_ai", Ai, 32'h0);
        chk("mid_pc", PCOut, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
